// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: access-type encoding (funct3), FSM state encoding, full-word
// byte-enable constant, and the legality / alignment checks applied to a
// request before it is allowed onto the data bus.
package lsu_pkg;

  typedef enum logic [2:0] {
    MT_B  = 3'b000,
    MT_H  = 3'b001,
    MT_W  = 3'b010,
    MT_BU = 3'b100,
    MT_HU = 3'b101
  } mem_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Unsigned load types have no store counterpart.
  function automatic logic type_legal(input logic [2:0] t, input logic we);
    logic ok;
    case (t)
      MT_B, MT_H, MT_W: ok = 1'b1;
      MT_BU, MT_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Size is carried in t[1:0]; bytes can never be misaligned.
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    logic bad;
    case (t[1:0])
      2'b01:   bad = a[0];
      2'b10:   bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit and data memory.
// Latency: n/a (wires only).
// Backpressure: bus_req/fields held until bus_gnt; read data returned on bus_rvalid.
//
// master: LSU side (drives request fields, receives gnt/rvalid/rdata).
// slave:  memory side.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Store lane steering (byte enables + data replication) and load lane extraction/extension.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: st_size_i/st_off_i/st_data_i -> be_o/wdata_o (store side);
//        ld_type_i/ld_off_i/rdata_i -> ld_data_o (load side).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Data is replicated across all lanes so the memory only has to honour be.
  always_comb begin
    be_o    = BE_ALL;
    wdata_o = st_data_i;
    case (st_size_i)
      2'b00: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        be_o    = BE_ALL;
        wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    ld_byte   = rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half   = rdata_i[{ld_off_i[1], 4'b0000} +: 16];
    ld_data_o = rdata_i;
    case (ld_type_i)
      MT_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MT_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      MT_BU:   ld_data_o = {24'd0, ld_byte};
      MT_HU:   ld_data_o = {16'd0, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Turns one pipeline load/store into a single word-aligned bus transaction; extends load data.
// Latency: store IDLE->DONE 3 cycles, load 4 cycles minimum (gnt/rvalid immediate).
// Backpressure: stall holds the pipeline until DONE; bus fields held until bus_gnt.
//
// Ports: clk, rst_n (async active-low); memRead/memWrite/memType/addr/store_data
// from execute; stall, load_data, load_valid, access_err to the pipeline;
// bus (load_store_unit_if.master) to data memory.
// Optional: define LSU_TIMEOUT_EN to abort a bus wait after TIMEOUT_CYCLES cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      memRead,
  input  logic                      memWrite,
  input  logic [2:0]                memType,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  output logic                      stall,
  output logic [31:0]               load_data,
  output logic                      load_valid,
  output logic                      access_err,
  load_store_unit_if.master         bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;
  localparam logic [1:0] S_WAIT = WAIT;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  type_q, type_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        err_q, err_d;

  logic        req_in;
  logic        fault_in;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;
  logic        timeout;

  // A simultaneous read+write is treated as a store.
  assign req_in   = memRead | memWrite;
  assign fault_in = ~type_legal(memType, memWrite) | misaligned(memType, addr[1:0]);

  // Store lanes come from the live inputs so they can be registered on entry to REQ;
  // load extraction uses the latched type/offset.
  lsu_align u_align (
    .st_size_i (memType[1:0]),
    .st_off_i  (addr[1:0]),
    .st_data_i (store_data),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_type_i (type_q),
    .ld_off_i  (addr_q[1:0]),
    .rdata_i   (bus.bus_rdata),
    .ld_data_o (ld_ext)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Restarts from zero whenever the FSM enters REQ or WAIT.
  always_comb begin
    cnt_d = '0;
    if ((state_q == S_REQ || state_q == S_WAIT) && state_d == state_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q == N-1 marks the N-th waiting cycle.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    type_d       = type_q;
    we_d         = we_q;
    req_d        = req_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_in) begin
          if (fault_in) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr;
            type_d  = memType;
            we_d    = memWrite;
            be_d    = st_be;
            wdata_d = st_wdata;
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (timeout) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (bus.bus_rvalid) begin
          load_data_d  = ld_ext;
          load_valid_d = 1'b1;
          state_d      = S_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        // The completed instruction is still on the inputs this cycle; ignore it.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      type_q       <= '0;
      we_q         <= 1'b0;
      req_q        <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      type_q       <= type_d;
      we_q         <= we_d;
      req_q        <= req_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
    end
  end

  assign stall = (state_q == S_REQ) | (state_q == S_WAIT) | ((state_q == S_IDLE) & req_in);

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign access_err = err_q;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  memType;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        access_err;

  int vecs    = 0;
  int miscmp  = 0;
  logic [31:0] last_ld = '0;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memType    (memType),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .access_err (access_err),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int sz_of(input logic [2:0] mt);
    return 1 << mt[1:0];
  endfunction

  function automatic logic ref_fault(input logic wr, input logic [2:0] mt, input logic [31:0] a);
    logic legal;
    legal = (mt == 3'd0 || mt == 3'd1 || mt == 3'd2 || mt == 3'd4 || mt == 3'd5)
            && !(wr && (mt == 3'd4 || mt == 3'd5));
    if (!legal) return 1'b1;
    return (a % sz_of(mt)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] mt, input logic [31:0] a);
    int n;
    int off;
    n   = sz_of(mt);
    off = int'(a % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] mt, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = sz_of(mt);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] mt, input logic [31:0] a,
                                           input logic [31:0] rd);
    int n;
    longint v;
    n = sz_of(mt);
    if (n >= 4) return rd;
    v = longint'(rd >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (!mt[2] && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge with the FSM idle; leaves the same way.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] mt,
                            input logic [31:0] a, input logic [31:0] d,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rdat);
    logic flt;
    flt = ref_fault(wr, mt, a);
    memRead = rd; memWrite = wr; memType = mt; addr = a; store_data = d;
    bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
    @(negedge clk);
    check("idle_stall", stall, 1);
    check("idle_noreq", bus_if.bus_req, 0);
    if (flt) begin
      @(posedge clk); #1;
      memRead = 0; memWrite = 0;
      @(negedge clk);
      check("fault_err", access_err, 1);
      check("fault_stall", stall, 0);
      check("fault_noreq", bus_if.bus_req, 0);
      check("fault_nolv", load_valid, 0);
      check("fault_ldhold", load_data, last_ld);
    end else begin
      for (int k = 0; k <= gnt_dly; k++) begin
        @(posedge clk); #1;
        bus_if.bus_gnt = (k == gnt_dly);
        @(negedge clk);
        check("req_req", bus_if.bus_req, 1);
        check("req_we", bus_if.bus_we, wr);
        check("req_addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
        check("req_be", bus_if.bus_be, ref_be(mt, a));
        if (wr) check("req_wdata", bus_if.bus_wdata, ref_wdata(mt, d));
        check("req_stall", stall, 1);
      end
      @(posedge clk); #1;
      bus_if.bus_gnt = 1'b0;
      if (!wr) begin
        for (int j = 0; j <= rv_dly; j++) begin
          bus_if.bus_rvalid = (j == rv_dly);
          bus_if.bus_rdata  = (j == rv_dly) ? rdat : $urandom;
          @(negedge clk);
          check("wait_stall", stall, 1);
          check("wait_noreq", bus_if.bus_req, 0);
          check("wait_nolv", load_valid, 0);
          @(posedge clk); #1;
        end
        last_ld = ref_load(mt, a, rdat);
      end
      bus_if.bus_rvalid = 1'b0;
      memRead = 0; memWrite = 0;
      @(negedge clk);
      check("done_stall", stall, 0);
      check("done_noreq", bus_if.bus_req, 0);
      check("done_lv", load_valid, !wr);
      check("done_noerr", access_err, 0);
      check("done_ldata", load_data, last_ld);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("after_lv", load_valid, 0);
    check("after_err", access_err, 0);
    check("after_stall", stall, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  mt;
    logic [31:0] a;
    logic [1:0]  rw;
    rst_n = 0; memRead = 0; memWrite = 0; memType = 0; addr = 0; store_data = 0;
    bus_if.bus_gnt = 0; bus_if.bus_rvalid = 0; bus_if.bus_rdata = 0;

    // reset state
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_req", bus_if.bus_req, 0);
    check("rst_we", bus_if.bus_we, 0);
    check("rst_addr", bus_if.bus_addr, 0);
    check("rst_be", bus_if.bus_be, 0);
    check("rst_wdata", bus_if.bus_wdata, 0);
    check("rst_ld", load_data, 0);
    check("rst_lv", load_valid, 0);
    check("rst_err", access_err, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // directed cases
    run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);           // SW
    run_access(1, 0, 3'b000, 32'h203, 0, 0, 1, 32'h80112233);           // LB
    check("lb_value", last_ld, 32'hFFFFFF80);
    run_access(1, 0, 3'b100, 32'h203, 0, 0, 1, 32'h80112233);           // LBU
    check("lbu_value", load_data, 32'h00000080);
    run_access(0, 1, 3'b001, 32'h12, 32'h0000ABCD, 5, 0, 0);            // SH, slow gnt
    run_access(1, 0, 3'b010, 32'h102, 0, 0, 0, 0);                      // misaligned LW
    run_access(1, 0, 3'b011, 32'h100, 0, 0, 0, 0);                      // illegal type
    run_access(0, 1, 3'b100, 32'h100, 32'h55, 0, 0, 0);                 // store with BU
    run_access(1, 1, 3'b000, 32'h301, 32'h000000A5, 1, 0, 0);           // rd+wr -> SB
    run_access(1, 0, 3'b001, 32'h402, 0, 2, 3, 32'h9ABC1234);           // LH upper half

    // reset in the middle of an LHU
    memRead = 1; memType = 3'b101; addr = 32'h40;
    @(posedge clk); #1;
    bus_if.bus_gnt = 1;
    @(posedge clk); #1;
    bus_if.bus_gnt = 0;
    #2;
    memRead = 0;
    rst_n = 0;
    #1;
    @(negedge clk);
    check("mrst_req", bus_if.bus_req, 0);
    check("mrst_stall", stall, 0);
    check("mrst_addr", bus_if.bus_addr, 0);
    check("mrst_ld", load_data, 0);
    check("mrst_lv", load_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;
    last_ld = '0;
    bus_if.bus_rvalid = 1; bus_if.bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("stray_lv", load_valid, 0);
    check("stray_req", bus_if.bus_req, 0);
    @(posedge clk); #1;
    bus_if.bus_rvalid = 0;
    @(negedge clk);
    check("stray_lv2", load_valid, 0);
    check("stray_ld", load_data, 0);
    check("stray_stall", stall, 0);
    @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
    // gnt never arrives: request abandoned after 4 cycles
    memRead = 1; memType = 3'b010; addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("to_req", bus_if.bus_req, 1);
    end
    @(posedge clk); #1;
    memRead = 0;
    @(negedge clk);
    check("to_noreq", bus_if.bus_req, 0);
    check("to_err", access_err, 1);
    check("to_nolv", load_valid, 0);
    check("to_ldhold", load_data, last_ld);
    @(posedge clk); #1;
    @(posedge clk); #1;
`endif

    // randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      rw = 2'($urandom_range(1, 3));
      mt = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && mt[1:0] != 2'b00) a[0] = 1'b0;
      if ($urandom_range(0, 3) != 0 && mt[1:0] == 2'b10) a[1] = 1'b0;
      run_access(rw[0], rw[1], mt, a, $urandom, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
